// File: rtl/systolic_ctrl_if.sv
// Handshake, operand-memory and array-feed bundle for systolic_ctrl.
// master: the environment (start requester, operand memories, array sink).
// slave : the sequencer itself.
interface systolic_ctrl_if #(
   parameter int N  = 32,
   parameter int M  = 8,
   parameter int KW = 8
);
   logic                  start;
   logic [KW-1:0]         k_len;
   logic                  busy;
   logic                  done;
   logic                  rd_en;
   logic [KW-1:0]         rd_addr;
   logic [M-1:0][N-1:0]   a_rd_data;
   logic [M-1:0][N-1:0]   b_rd_data;
   logic                  arr_rst;
   logic                  arr_en;
   logic [M-1:0][N-1:0]   arr_x;
   logic [M-1:0][N-1:0]   arr_y;

   modport master (
      output start, k_len, a_rd_data, b_rd_data,
      input  busy, done, rd_en, rd_addr, arr_rst, arr_en, arr_x, arr_y
   );

   modport slave (
      input  start, k_len, a_rd_data, b_rd_data,
      output busy, done, rd_en, rd_addr, arr_rst, arr_en, arr_x, arr_y
   );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for one MxM systolic-array pass C = A(MxK) * B(KxM).
// Clears the array, streams K operand columns/rows from memory, applies the
// diagonal skew so A[i][k] and B[k][j] meet in PE(i,j), drains, then pulses done.
module systolic_ctrl #(
   parameter int N  = 32,
   parameter int M  = 8,
   parameter int KW = 8
) (
   input  logic            clk,
   input  logic            rst,
   systolic_ctrl_if.slave  bus
);
   localparam int DW = $clog2(2 * M);
   localparam logic [DW-1:0] DLAST = DW'(2 * M - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [KW-1:0] k_q;
   logic [KW-1:0] kcnt_q;
   logic [KW-1:0] kcnt_d;
   logic [KW-1:0] k_last;
   logic [KW-1:0] rd_addr_q;
   logic [DW-1:0] dcnt_q;
   logic          busy_q;
   logic          done_q;
   logic          rd_en_q;
   logic          rd_vld_q;
   logic          arr_rst_q;
   logic          arr_en_q;
   logic          skew_clr;
   logic          skew_shift;

   logic [M-1:0][N-1:0] fa;
   logic [M-1:0][N-1:0] fb;
   logic [M-1:0][N-1:0] skew_x;
   logic [M-1:0][N-1:0] skew_y;

   assign kcnt_d = kcnt_q + KW'(1);
   // k_q is never 0 while in FEED, so k_last cannot underflow there.
   assign k_last = k_q - KW'(1);

   // Pass sequencer; every output is registered and set for the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         kcnt_q    <= '0;
         dcnt_q    <= '0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         arr_rst_q <= 1'b0;
         arr_en_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  k_q       <= bus.k_len;
                  state_q   <= S_CLEAR;
                  busy_q    <= 1'b1;
                  arr_rst_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               arr_rst_q <= 1'b0;
               kcnt_q    <= '0;
               rd_addr_q <= '0;
               if (k_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_FEED;
                  rd_en_q <= 1'b1;
               end
            end
            S_FEED: begin
               // From the second FEED cycle on, operand data is arriving.
               arr_en_q <= 1'b1;
               if (kcnt_q == k_last) begin
                  state_q <= S_DRAIN;
                  rd_en_q <= 1'b0;
                  dcnt_q  <= '0;
               end else begin
                  kcnt_q    <= kcnt_d;
                  rd_addr_q <= kcnt_d;
               end
            end
            S_DRAIN: begin
               if (dcnt_q == DLAST) begin
                  state_q  <= S_DONE;
                  arr_en_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  dcnt_q <= dcnt_q + DW'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Memory returns data one cycle after the read strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_vld_q <= 1'b0;
      else     rd_vld_q <= rd_en_q;
   end

   // Invalid cycles feed zeros so surplus enable cycles add nothing.
   assign fa = rd_vld_q ? bus.a_rd_data : '0;
   assign fb = rd_vld_q ? bus.b_rd_data : '0;

   assign skew_clr   = (state_q == S_CLEAR);
   assign skew_shift = arr_en_q | rd_vld_q;

   // Lane 0 goes straight through; lane g is delayed g cycles.
   assign skew_x[0] = fa[0];
   assign skew_y[0] = fb[0];

   for (genvar gi = 1; gi < M; gi++) begin : g_skew
      logic [N-1:0] sx_q [gi];
      logic [N-1:0] sy_q [gi];

      // Zero-filled delay line of depth gi for row gi and column gi.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int d = 0; d < gi; d++) begin
               sx_q[d] <= '0;
               sy_q[d] <= '0;
            end
         end else if (skew_clr) begin
            for (int d = 0; d < gi; d++) begin
               sx_q[d] <= '0;
               sy_q[d] <= '0;
            end
         end else if (skew_shift) begin
            sx_q[0] <= fa[gi];
            sy_q[0] <= fb[gi];
            for (int d = 1; d < gi; d++) begin
               sx_q[d] <= sx_q[d-1];
               sy_q[d] <= sy_q[d-1];
            end
         end
      end

      assign skew_x[gi] = sx_q[gi-1];
      assign skew_y[gi] = sy_q[gi-1];
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.arr_rst = arr_rst_q;
   assign bus.arr_en  = arr_en_q;
   assign bus.arr_x   = skew_x;
   assign bus.arr_y   = skew_y;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: behavioural operand memories with 1-cycle
// read latency and a behavioural output-stationary MxM systolic array.
module tb_systolic_ctrl;
   localparam int N  = 32;
   localparam int M  = 4;
   localparam int KW = 8;

   logic clk;
   logic rst;

   systolic_ctrl_if #(.N(N), .M(M), .KW(KW)) bus ();

   systolic_ctrl #(.N(N), .M(M), .KW(KW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // operand memories: entry k holds column k of A / row k of B
   logic [M-1:0][N-1:0] a_mem [256];
   logic [M-1:0][N-1:0] b_mem [256];

   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.a_rd_data <= a_mem[bus.rd_addr];
         bus.b_rd_data <= b_mem[bus.rd_addr];
      end
   end

   // behavioural systolic array (cleared only by arr_rst)
   logic signed [N-1:0] acc_m [M][M];
   logic signed [N-1:0] x_r   [M][M];
   logic signed [N-1:0] y_r   [M][M];

   always @(posedge clk) begin
      logic signed [N-1:0] xin;
      logic signed [N-1:0] yin;
      if (bus.arr_rst) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
               acc_m[i][j] <= '0;
               x_r[i][j]   <= '0;
               y_r[i][j]   <= '0;
            end
      end else if (bus.arr_en) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
               if (j == 0) xin = $signed(bus.arr_x[i]);
               else        xin = x_r[i][j-1];
               if (i == 0) yin = $signed(bus.arr_y[j]);
               else        yin = y_r[i-1][j];
               acc_m[i][j] <= acc_m[i][j] + xin * yin;
               x_r[i][j]   <= xin;
               y_r[i][j]   <= yin;
            end
      end
   end

   int checks = 0;
   int errors = 0;
   int exp_m [M][M];

   // pass statistics
   int done_cyc, busy_pre, en_cnt, en_runs, rd_cnt, rst_cnt;
   int x0_first, x3_first, y0_first, y3_first;
   int addr_seen [256];

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_acc(input string tag);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++)
            chk($sformatf("%s_acc[%0d][%0d]", tag, i, j), acc_m[i][j], exp_m[i][j]);
   endtask

   // A = I (first 4 columns), B rows 0..3 = 1..16 row-major, rest zero
   task automatic load_ident_b16();
      for (int k = 0; k < 256; k++)
         for (int i = 0; i < M; i++) begin
            a_mem[k][i] = (k < M && i == k) ? 32'd1 : 32'd0;
            b_mem[k][i] = (k < M) ? 32'(4 * k + i + 1) : 32'd0;
         end
   endtask

   task automatic load_const(input int av, input int bv);
      for (int k = 0; k < 256; k++)
         for (int i = 0; i < M; i++) begin
            a_mem[k][i] = 32'(av);
            b_mem[k][i] = 32'(bv);
         end
   endtask

   // start a pass from IDLE, observe each cycle until done (bounded)
   task automatic run_pass(input int k, input int limit);
      logic prev_en;
      done_cyc = -1; busy_pre = 0; en_cnt = 0; en_runs = 0; rd_cnt = 0; rst_cnt = 0;
      x0_first = -1; x3_first = -1; y0_first = -1; y3_first = -1;
      for (int a = 0; a < 256; a++) addr_seen[a] = 0;
      prev_en = 1'b0;
      bus.k_len = 8'(k);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         if (bus.arr_en) begin
            en_cnt++;
            if (!prev_en) en_runs++;
         end
         prev_en = bus.arr_en;
         if (bus.rd_en) begin
            rd_cnt++;
            addr_seen[bus.rd_addr]++;
         end
         if (bus.arr_rst) rst_cnt++;
         if (x0_first < 0 && bus.arr_x[0] != '0) x0_first = c;
         if (x3_first < 0 && bus.arr_x[3] != '0) x3_first = c;
         if (y0_first < 0 && bus.arr_y[0] != '0) y0_first = c;
         if (y3_first < 0 && bus.arr_y[3] != '0) y3_first = c;
         if (bus.done) begin
            done_cyc = c;
            break;
         end
         if (bus.busy) busy_pre++;
         step();
      end
      chk("pass_completed", (done_cyc >= 0), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int good, d_n, r_n, d1, d2, seen;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.k_len = '0;
      load_ident_b16();
      repeat (3) @(posedge clk);
      #1;
      // reset state
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_arr_rst", bus.arr_rst, 0);
      chk("rst_arr_en", bus.arr_en, 0);
      chk("rst_rd_addr", bus.rd_addr, 0);
      chk("rst_arr_x_zero", (bus.arr_x == '0), 1);
      rst = 1'b0;
      step();
      chk("idle_busy", bus.busy, 0);

      // 1: A=I, B=1..16, K=4
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) exp_m[i][j] = 4 * i + j + 1;
      run_pass(4, 40);
      chk("t1_done_cycle", done_cyc, 13);
      chk("t1_busy_before_done", busy_pre, 12);
      chk("t1_busy_at_done", bus.busy, 1);
      chk("t1_arr_en_cycles", en_cnt, 10);
      chk("t1_arr_en_runs", en_runs, 1);
      chk("t1_rd_cnt", rd_cnt, 4);
      chk("t1_arr_rst_pulses", rst_cnt, 1);
      check_acc("t1");
      step();
      chk("t1_done_pulse_ends", bus.done, 0);
      chk("t1_busy_ends", bus.busy, 0);
      check_acc("t1_stable");

      // 2: all 2, K=7
      load_const(2, 2);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) exp_m[i][j] = 28;
      run_pass(7, 40);
      chk("t2_done_cycle", done_cyc, 16);
      chk("t2_arr_en_cycles", en_cnt, 13);
      chk("t2_arr_en_runs", en_runs, 1);
      chk("t2_rd_cnt", rd_cnt, 7);
      good = 0;
      for (int a = 0; a < 7; a++) if (addr_seen[a] == 1) good++;
      chk("t2_rd_addr_once_each", good, 7);
      check_acc("t2");
      step();

      // 3: K=0 after a nonzero pass
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) exp_m[i][j] = 0;
      run_pass(0, 20);
      chk("t3_done_cycle", done_cyc, 2);
      chk("t3_arr_rst_pulses", rst_cnt, 1);
      chk("t3_rd_cnt", rd_cnt, 0);
      chk("t3_arr_en_cycles", en_cnt, 0);
      check_acc("t3");
      step();

      // 4: start held high for 40 cycles, K=2
      load_ident_b16();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) exp_m[i][j] = (i < 2) ? 4 * i + j + 1 : 0;
      bus.k_len = 8'd2;
      bus.start = 1'b1;
      step();
      d_n = 0; r_n = 0; d1 = -1; d2 = -1;
      for (int c = 1; c <= 40; c++) begin
         if (bus.arr_rst) r_n++;
         if (bus.done) begin
            d_n++;
            if (d_n == 1) d1 = c;
            if (d_n == 2) d2 = c;
            check_acc($sformatf("t4_pass%0d", d_n));
         end
         step();
      end
      bus.start = 1'b0;
      chk("t4_done_pulses", d_n, 3);
      chk("t4_arr_rst_pulses", r_n, 4);
      chk("t4_first_done", d1, 11);
      chk("t4_second_done", d2, 23);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.done) begin
            seen = 1;
            break;
         end
         step();
      end
      chk("t4_last_pass_done", seen, 1);
      step();
      step();
      chk("t4_no_retrigger", bus.busy, 0);

      // 5: async reset during DRAIN of a K=5 pass, then fresh K=3 pass
      bus.k_len = 8'd5;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (8) step();
      chk("t5_in_drain", bus.arr_en, 1);
      rst = 1'b1;
      #2;
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_done", bus.done, 0);
      chk("t5_rst_rd_en", bus.rd_en, 0);
      chk("t5_rst_arr_rst", bus.arr_rst, 0);
      chk("t5_rst_arr_en", bus.arr_en, 0);
      chk("t5_rst_rd_addr", bus.rd_addr, 0);
      chk("t5_rst_arr_x_zero", (bus.arr_x == '0), 1);
      chk("t5_rst_arr_y_zero", (bus.arr_y == '0), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      for (int k = 0; k < 256; k++)
         for (int i = 0; i < M; i++) begin
            a_mem[k][i] = (k < 3 && i == k) ? 32'd1 : 32'd0;
            b_mem[k][i] = (k < 3 && i < 3) ? 32'(3 * k + i + 1) : 32'd0;
         end
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) exp_m[i][j] = (i < 3 && j < 3) ? 3 * i + j + 1 : 0;
      run_pass(3, 40);
      chk("t5_done_cycle", done_cyc, 12);
      check_acc("t5");
      step();

      // 6: signed operands, skew timing
      load_const(-1, 3);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) exp_m[i][j] = -12;
      run_pass(4, 40);
      check_acc("t6");
      chk("t6_x0_first", x0_first, 3);
      chk("t6_x_skew", x3_first - x0_first, 3);
      chk("t6_y_skew", y3_first - y0_first, 3);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
